// File: rtl/fp_alu_sequencer_pkg.sv
// Shared opcodes, FSM states, flag bit positions and response record
// for the FP ALU sequencer and its response buffer.
package fp_alu_sequencer_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_ILLEGAL = 2'd2
  } state_e;

  localparam int FLAG_ILLEGAL = 3;
  localparam int FLAG_EXC     = 2;
  localparam int FLAG_OVF     = 1;
  localparam int FLAG_UNF     = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } rsp_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/fp_rsp_fifo.sv
// Small response FIFO; head entry is presented combinationally, popped on pop_i.
module fp_rsp_fifo
  import fp_alu_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  rsp_t data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output rsp_t head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rsp_t           mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage needs no reset: the head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fp_alu_sequencer.sv
// Issues one FP operation at a time to an external combinational ALU, waits a
// fixed settle time, then queues {result, flags, tag} for the response port.
module fp_alu_sequencer
  import fp_alu_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int RSP_DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_tag,
  output logic [31:0] alu_a_operand,
  output logic [31:0] alu_b_operand,
  output logic [3:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic        alu_exception,
  input  logic        alu_overflow,
  input  logic        alu_underflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  rsp_tag
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  tag_q, tag_d;
  logic        rdy_en_q;
  logic        accept;
  logic        push;
  rsp_t        push_data;
  rsp_t        head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  exec_flags;
  logic        in_exec;

  // rdy_en_q holds cmd_ready low until the first edge after reset release.
  assign cmd_ready = rdy_en_q && (state_q == ST_IDLE) && !fifo_full;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    exec_flags               = '0;
    exec_flags[FLAG_EXC]     = alu_exception;
    exec_flags[FLAG_OVF]     = alu_overflow;
    exec_flags[FLAG_UNF]     = alu_underflow;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = cmd_op;
          a_d   = cmd_a;
          b_d   = cmd_b;
          tag_d = cmd_tag;
          if (op_is_legal(cmd_op)) begin
            state_d = ST_EXEC;
            cnt_d   = 4'(SETTLE_CYCLES - 1);
          end else begin
            state_d = ST_ILLEGAL;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          push      = 1'b1;
          push_data = '{result: alu_result, flags: exec_flags, tag: tag_q};
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ILLEGAL: begin
        push      = 1'b1;
        push_data = '{result: 32'h0, flags: 4'b1000, tag: tag_q};
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign in_exec       = (state_q == ST_EXEC);
  assign alu_operation = in_exec ? op_q : OP_NOP;
  assign alu_a_operand = in_exec ? a_q : 32'h0;
  assign alu_b_operand = in_exec ? b_q : 32'h0;

  fp_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (rsp_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign rsp_valid  = !fifo_empty;
  assign rsp_result = rsp_valid ? head.result : 32'h0;
  assign rsp_flags  = rsp_valid ? head.flags : 4'h0;
  assign rsp_tag    = rsp_valid ? head.tag : 4'h0;

endmodule
